// File: rtl/systolic_feed_ctrl.sv
// Tile sequencer for the skew-feed FIFO bank: clear, load N beats, drain the
// diagonal wavefront, then report done (or aborted) to the tile scheduler.
module systolic_feed_ctrl #(
    parameter int N         = 32,
    parameter int DRAIN_LEN = 2*N+2,
    parameter int TCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic              fifo_clr,
    output logic              fifo_wrt,
    output logic              fifo_rd,
    output logic              out_valid,
    output logic [N-1:0]      lane_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [TCNT_W-1:0] tile_cnt
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [LW-1:0] LOAD_LAST  = LW'(N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       load_cnt_q, load_cnt_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
    logic                fifo_clr_q, fifo_clr_d;
    logic                fifo_wrt_q, fifo_wrt_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0]        lane_valid_q, lane_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [TCNT_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic                rd_s;

    // Lane i holds real data on beats i..i+N-1 of the drained wavefront.
    function automatic logic [N-1:0] lane_mask(input logic [DW-1:0] beat);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (int'(beat) >= i) && (int'(beat) <= i + N - 1);
        end
        return m;
    endfunction

    // Next-state, counters and the registered-output images of the next state.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        // Read strobe follows the array edge directly so a stall costs no beat.
        rd_s        = (state_q == S_DRAIN) && !stall;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (load_cnt_q == LOAD_LAST) begin
                    state_d    = S_GAP;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + LW'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (rd_s) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = S_DONE;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_ABORT) begin
            load_cnt_d  = '0;
            drain_cnt_d = '0;
        end else begin
            load_cnt_d  = load_cnt_d;
            drain_cnt_d = drain_cnt_d;
        end

        fifo_clr_d  = (state_d == S_CLEAR) || (state_d == S_ABORT);
        fifo_wrt_d  = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        aborted_d   = (state_d == S_ABORT);
        out_valid_d = rd_s && (state_d != S_ABORT);
        if (out_valid_d) begin
            lane_valid_d = lane_mask(drain_cnt_q);
        end else begin
            lane_valid_d = '0;
        end
        if (done_d) begin
            tile_cnt_d = tile_cnt_q + TCNT_W'(1);
        end else begin
            tile_cnt_d = tile_cnt_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            fifo_clr_q   <= 1'b0;
            fifo_wrt_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            lane_valid_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tile_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            fifo_clr_q   <= fifo_clr_d;
            fifo_wrt_q   <= fifo_wrt_d;
            out_valid_q  <= out_valid_d;
            lane_valid_q <= lane_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            tile_cnt_q   <= tile_cnt_d;
        end
    end

    assign fifo_clr   = fifo_clr_q;
    assign fifo_wrt   = fifo_wrt_q;
    assign fifo_rd    = rd_s;
    assign out_valid  = out_valid_q;
    assign lane_valid = lane_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign tile_cnt   = tile_cnt_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl with N=4, DRAIN_LEN=10: per-cycle
// expected outputs are queued by the stimulus and checked by a monitor.
module tb_systolic_feed_ctrl;

    typedef struct packed {
        logic        clr;
        logic        wrt;
        logic        rd;
        logic        ov;
        logic [3:0]  lv;
        logic        busy;
        logic        done;
        logic        ab;
        logic [15:0] tcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        stall;
    logic        fifo_clr;
    logic        fifo_wrt;
    logic        fifo_rd;
    logic        out_valid;
    logic [3:0]  lane_valid;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] tile_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    total;
    int    bad;
    exp_t  zero_e;

    systolic_feed_ctrl #(.N(4), .DRAIN_LEN(10), .TCNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .fifo_clr   (fifo_clr),
        .fifo_wrt   (fifo_wrt),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .tile_cnt   (tile_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile timeline from the start pulse at c=0: clear c1, load c2-5, gap c6,
    // 10 read strobes from c7 with an optional stall window [s0, s0+len).
    function automatic logic rd_at(int c, int s0, int len);
        return (c >= 7) && (c <= 16 + len) && !((c >= s0) && (c < s0 + len));
    endfunction

    function automatic exp_t tile_exp(int c, int s0, int len, logic [15:0] tc);
        exp_t e;
        int   beat;
        logic rdp;
        e      = '0;
        e.clr  = (c == 1);
        e.wrt  = (c >= 2) && (c <= 5);
        e.busy = (c >= 1) && (c <= 17 + len);
        e.done = (c == 17 + len);
        e.tcnt = (c >= 17 + len) ? tc + 16'd1 : tc;
        e.rd   = rd_at(c, s0, len);
        rdp    = rd_at(c - 1, s0, len);
        e.ov   = rdp;
        beat   = 0;
        for (int k = 7; k <= c - 2; k++) begin
            if (rd_at(k, s0, len)) beat++;
        end
        for (int i = 0; i < 4; i++) begin
            e.lv[i] = rdp && (beat >= i) && (beat <= i + 3);
        end
        return e;
    endfunction

    // Abort raised (together with stall) at cycle a of a tile.
    function automatic exp_t abort_exp(int c, int a, logic [15:0] tc);
        exp_t e;
        if (c <= a) begin
            e = tile_exp(c, a, 1, tc);
        end else begin
            e      = '0;
            e.tcnt = tc;
            if (c == a + 1) begin
                e.clr  = 1'b1;
                e.ab   = 1'b1;
                e.busy = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic cyc(input logic st, input logic ab, input logic sl,
                       input exp_t e, input string nm);
        @(posedge clk);
        #1;
        start = st;
        abort = ab;
        stall = sl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{fifo_clr, fifo_wrt, fifo_rd, out_valid, lane_valid,
                       busy, done, aborted, tile_cnt};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s t=%0t got clr=%b wrt=%b rd=%b ov=%b lv=%b busy=%b done=%b ab=%b tcnt=%0d expected clr=%b wrt=%b rd=%b ov=%b lv=%b busy=%b done=%b ab=%b tcnt=%0d",
                             nm, $time, a.clr, a.wrt, a.rd, a.ov, a.lv, a.busy, a.done, a.ab, a.tcnt,
                             e.clr, e.wrt, e.rd, e.ov, e.lv, e.busy, e.done, e.ab, e.tcnt);
                end
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        zero_e = '0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        stall  = 1'b0;

        cyc(1'b0, 1'b0, 1'b0, zero_e, "reset");
        cyc(1'b0, 1'b0, 1'b0, zero_e, "reset");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, zero_e, "idle");

        // Basic tile; start repeated at c5 and c17 must be dropped.
        for (int c = 0; c <= 17; c++) begin
            cyc((c == 0) || (c == 5) || (c == 17), 1'b0, 1'b0,
                tile_exp(c, 0, 0, 16'd0), "basic");
        end
        // Back-to-back tile started in IDLE, stalled for c9-11.
        for (int c = 0; c <= 20; c++) begin
            cyc(c == 0, 1'b0, (c >= 9) && (c <= 11),
                tile_exp(c, 9, 3, 16'd1), "stall");
        end
        zero_e.tcnt = 16'd2;
        cyc(1'b0, 1'b0, 1'b0, zero_e, "idle2");

        for (int c = 0; c <= 6; c++) begin
            cyc(c == 0, c == 3, c == 3, abort_exp(c, 3, 16'd2), "abort_load");
        end
        for (int c = 0; c <= 11; c++) begin
            cyc(c == 0, c == 9, c == 9, abort_exp(c, 9, 16'd2), "abort_drain_stall");
        end

        // Asynchronous reset in the middle of DRAIN.
        for (int c = 0; c <= 9; c++) begin
            cyc(c == 0, 1'b0, 1'b0, tile_exp(c, 0, 0, 16'd2), "pre_rst");
        end
        zero_e.tcnt = 16'd0;
        @(posedge clk);
        #1;
        exp_q.push_back(zero_e);
        name_q.push_back("rst_async");
        #2;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, zero_e, "rst_hold");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, 1'b0, zero_e, "post_rst");
        end
        for (int c = 0; c <= 17; c++) begin
            cyc(c == 0, 1'b0, 1'b0, tile_exp(c, 0, 0, 16'd0), "after_rst");
        end

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
